pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline with the one-way data cache. It detects load-use hazards, taken-branch flushes and data-cache miss stalls, and drives the hold/bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also runs a miss-duration watchdog, which freezes the pipeline on a hung cache.

## Interface
- MISS_TIMEOUT, 1024: miss cycles allowed before the watchdog trips (≥2).
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  pipeline run enable; low = controller idle, all outputs 0
- idex_memrd_i  in  1  instruction in EX is a load
- idex_rt_i  in  5  load destination register in EX
- ifid_rs_i  in  5  rs of instruction in ID
- ifid_rt_i  in  5  rt of instruction in ID
- ifid_uses_rt_i  in  1  ID instruction reads rt as a source
- branch_taken_i  in  1  branch in ID resolved taken
- dcache_stall_i  in  1  cache miss in progress (MEM access blocked)
- pc_stall_o  out  1  hold PC
- ifid_stall_o  out  1  hold IF/ID
- ifid_flush_o  out  1  zero IF/ID on next edge
- idex_stall_o  out  1  hold ID/EX
- idex_bubble_o  out  1  load NOP controls into ID/EX
- exmem_stall_o  out  1  hold EX/MEM
- memwb_bubble_o  out  1  load NOP controls into MEM/WB
- state_o  out  2  00 RUN, 01 MISS, 10 ERR
- err_o  out  1  sticky watchdog error
- lu_cnt_o  out  16  load-use stall count
- miss_cyc_o  out  32  miss stall cycle count
- flush_cnt_o  out  16  branch flush count

## Operation
- Load-use hazard (`lu`): `idex_memrd_i & idex_rt_i!=0 & (idex_rt_i==ifid_rs_i | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i))`.
- Miss condition (`miss`): `dcache_stall_i | state==MISS`. The combinational term makes the stall take effect in the same cycle the cache asserts.
- Stall outputs are combinational (Mealy) from state and inputs. Priority: ERR > miss > lu > branch.
- ERR or miss:
  - `pc_stall_o`, `ifid_stall_o`, `idex_stall_o`, `exmem_stall_o` = 1.
  - `memwb_bubble_o` = 1.
  - `idex_bubble_o` = 0, `ifid_flush_o` = 0.
- lu (no miss):
  - `pc_stall_o`, `ifid_stall_o`, `idex_bubble_o` = 1.
  - Everything else 0.
  - Branch flush is suppressed, because `branch_taken_i` is invalid while ID waits.
- `branch_taken_i` (no miss, no lu): `ifid_flush_o` = 1 only.
- A branch whose flush arrives during a miss is not lost. ID is held, so `branch_taken_i` stays asserted and the flush fires in the first non-stalled cycle.
- FSM transitions:
  - RUN → MISS when `dcache_stall_i`; `miss_cnt` loads 1.
  - MISS stays in MISS while `dcache_stall_i` and `miss_cnt` < MISS_TIMEOUT; `miss_cnt` increments.
  - MISS → RUN when `dcache_stall_i`=0. That cycle still stalls, so the cache's last-cycle data is captured once.
  - MISS → ERR when `miss_cnt`==MISS_TIMEOUT and `dcache_stall_i`=1; `err_o` sets.
  - ERR is absorbing until reset.
- `miss_cnt` width: `$clog2(MISS_TIMEOUT+1)`; cleared on entry to RUN.
- When `start_i`=0:
  - FSM holds its state and `miss_cnt` holds.
  - All stall/flush/bubble outputs are 0, except in ERR (the freeze persists).
  - Counters do not count.

## Timing
- Reset (async, `rst_i`=0): state RUN, `miss_cnt` 0, `err_o` 0, all counters 0. Every stall/flush/bubble output is 0 as soon as reset is asserted.
- Reset mid-miss: immediate return to RUN; the next cycle with `dcache_stall_i`=1 re-enters MISS.
- Stall/flush outputs: zero-latency combinational. State, `err_o` and counters update on `posedge clk_i`.
- A load-use stall lasts exactly 1 cycle. After the bubble, the load has moved to MEM and `lu` deasserts.
- Load-use with simultaneous miss: the miss governs. `lu` is re-evaluated after the miss ends, and the bubble then inserts once.
- Minimum miss stall is 2 cycles: the `dcache_stall_i` rise cycle plus the MISS exit cycle.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `lu_cnt_o` increments on each cycle `lu` stalls.
  - `miss_cyc_o` increments on each cycle `miss` is active.
  - `flush_cnt_o` increments on each `ifid_flush_o` cycle.
  - All counters are saturating and count only when `start_i`=1.
- Undefined: the three ports remain and are tied to 0; no counter flops are built.

## Test plan
- Load-use: `idex_memrd_i`=1, `idex_rt_i`=8, `ifid_rs_i`=8 → `pc_stall_o`/`ifid_stall_o`/`idex_bubble_o`=1 for one cycle. With `idex_rt_i`=0, no stall.
- rt-only hazard: `idex_rt_i`=9, `ifid_rt_i`=9, `ifid_uses_rt_i`=0 → no stall; the same inputs with `ifid_uses_rt_i`=1 → 1-cycle stall.
- Miss: `dcache_stall_i` high for 5 cycles → all holds active for 6 cycles, `state_o`=01 during the miss, back to 00 afterwards. With the macro defined, `miss_cyc_o`=6.
- Branch during miss: `branch_taken_i`=1 held throughout a 3-cycle miss → `ifid_flush_o`=0 during the miss, then 1 in the first free cycle; `flush_cnt_o`=1.
- Watchdog: MISS_TIMEOUT=4, `dcache_stall_i` stuck high → `err_o`=1 and `state_o`=10 after cycle 5. The pipeline stays frozen until `rst_i` pulses low, after which all outputs return to 0.
- Async reset mid-miss at cycle 2 → outputs 0 immediately, `state_o`=00, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and stall/flush controls back to it
interface pipeline_hazard_ctrl_if;
  logic        start_i;
  logic        idex_memrd_i;
  logic [4:0]  idex_rt_i;
  logic [4:0]  ifid_rs_i;
  logic [4:0]  ifid_rt_i;
  logic        ifid_uses_rt_i;
  logic        branch_taken_i;
  logic        dcache_stall_i;
  logic        pc_stall_o;
  logic        ifid_stall_o;
  logic        ifid_flush_o;
  logic        idex_stall_o;
  logic        idex_bubble_o;
  logic        exmem_stall_o;
  logic        memwb_bubble_o;
  logic [1:0]  state_o;
  logic        err_o;
  logic [15:0] lu_cnt_o;
  logic [31:0] miss_cyc_o;
  logic [15:0] flush_cnt_o;
  modport master (
    output start_i, idex_memrd_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           branch_taken_i, dcache_stall_i,
    input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_bubble_o,
           exmem_stall_o, memwb_bubble_o, state_o, err_o, lu_cnt_o, miss_cyc_o, flush_cnt_o
  );
  modport slave (
    input  start_i, idex_memrd_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           branch_taken_i, dcache_stall_i,
    output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_bubble_o,
           exmem_stall_o, memwb_bubble_o, state_o, err_o, lu_cnt_o, miss_cyc_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / branch-flush / dcache-miss stall sequencer with miss watchdog; optional perf counters under HAZARD_PERF_CNT_EN
module pipeline_hazard_ctrl #(
  parameter int MISS_TIMEOUT = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pipeline_hazard_ctrl_if.slave  bus
);
  localparam int CW = $clog2(MISS_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN = 2'b00, MISS = 2'b01, ERR = 2'b10} state_t;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_miss_cnt, w_miss_cnt_nxt;
  logic w_en, w_err, w_lu, w_miss, w_miss_act, w_lu_act, w_flush_act, w_freeze;
  assign w_en        = rst_i & bus.start_i;
  assign w_err       = r_state == ERR;
  assign w_lu        = bus.idex_memrd_i & (bus.idex_rt_i != 5'd0) &
                       ((bus.idex_rt_i == bus.ifid_rs_i) |
                        (bus.ifid_uses_rt_i & (bus.idex_rt_i == bus.ifid_rt_i)));
  assign w_miss      = bus.dcache_stall_i | (r_state == MISS);
  assign w_miss_act  = w_en & ~w_err & w_miss;
  assign w_lu_act    = w_en & ~w_err & ~w_miss & w_lu;
  assign w_flush_act = w_en & ~w_err & ~w_miss & ~w_lu & bus.branch_taken_i;
  assign w_freeze    = (rst_i & w_err) | w_miss_act;
  assign bus.pc_stall_o     = w_freeze | w_lu_act;
  assign bus.ifid_stall_o   = w_freeze | w_lu_act;
  assign bus.idex_stall_o   = w_freeze;
  assign bus.exmem_stall_o  = w_freeze;
  assign bus.memwb_bubble_o = w_freeze;
  assign bus.idex_bubble_o  = w_lu_act;
  assign bus.ifid_flush_o   = w_flush_act;
  assign bus.state_o        = r_state;
  assign bus.err_o          = w_err;
  // State and miss watchdog counter registers
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_state    <= RUN;
      r_miss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_miss_cnt <= w_miss_cnt_nxt;
    end
  // Next state: miss tracking, watchdog trip, everything held while not started
  always_comb begin
    w_state_nxt    = r_state;
    w_miss_cnt_nxt = r_miss_cnt;
    if (bus.start_i)
      case (r_state)
        RUN: if (bus.dcache_stall_i) begin
          w_state_nxt    = MISS;
          w_miss_cnt_nxt = CW'(1);
        end
        MISS: if (!bus.dcache_stall_i) begin
          w_state_nxt    = RUN;
          w_miss_cnt_nxt = '0;
        end else if (r_miss_cnt < CW'(MISS_TIMEOUT)) w_miss_cnt_nxt = r_miss_cnt + 1'b1;
        else w_state_nxt = ERR;
        default: w_state_nxt = ERR;
      endcase
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_lu_cnt, r_flush_cnt;
  logic [31:0] r_miss_cyc;
  // Saturating event counters, advancing only on enabled stall/flush cycles
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_lu_cnt    <= '0;
      r_flush_cnt <= '0;
      r_miss_cyc  <= '0;
    end else begin
      if (w_lu_act && !(&r_lu_cnt)) r_lu_cnt <= r_lu_cnt + 1'b1;
      if (w_flush_act && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_miss_act && !(&r_miss_cyc)) r_miss_cyc <= r_miss_cyc + 1'b1;
    end
  assign bus.lu_cnt_o    = r_lu_cnt;
  assign bus.flush_cnt_o = r_flush_cnt;
  assign bus.miss_cyc_o  = r_miss_cyc;
`else
  assign bus.lu_cnt_o    = '0;
  assign bus.flush_cnt_o = '0;
  assign bus.miss_cyc_o  = '0;
`endif
endmodule
